// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator for the RV32I ID stage.
// Decodes the instruction format from the opcode, sign-extends the
// immediate to XLEN and computes the PC-relative target (pc+offset for
// B/J, pc+4 otherwise). Results leave through a valid/ready stage built
// from a two-entry FIFO (head + skid) with flush support.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             drop both entries and any same-cycle push
//   in_valid_i/in_ready_o, inst_i, pc_i            upstream handshake
//   out_valid_o/out_ready_i, inst_o, pc_o, imm_o,
//   fmt_o, target_o, illegal_o                     downstream head entry
module imm_gen_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned BYTE_OFFSET = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     inst_o,
  output logic [PC_W-1:0] pc_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic [PC_W-1:0] target_o,
  output logic            illegal_o
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [PC_W-1:0] target;
    logic            illegal;
  } entry_t;

  // ---------------- combinational decode ----------------
  // Every immediate fits in 32 bits before extension, so it is built as a
  // 32-bit two's-complement value and then sign-extended/truncated with
  // signed size casts to XLEN and PC_W.
  logic [31:0]     imm32;
  logic [PC_W-1:0] offset;
  fmt_e            fmt_d;
  entry_t          new_e;

  always_comb begin
    imm32 = '0;
    fmt_d = FMT_ILL;
    unique case (inst_i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        fmt_d = FMT_I;
        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      7'b0100011: begin
        fmt_d = FMT_S;
        imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      7'b1100011: begin
        fmt_d = FMT_B;
        if (BYTE_OFFSET != 0)
          imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                   inst_i[11:8], 1'b0};
        else
          imm32 = {{20{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                   inst_i[11:8]};
      end
      7'b0110111, 7'b0010111: begin
        fmt_d = FMT_U;
        imm32 = {inst_i[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt_d = FMT_J;
        if (BYTE_OFFSET != 0)
          imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                   inst_i[30:21], 1'b0};
        else
          imm32 = {{12{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                   inst_i[30:21]};
      end
      7'b0110011: begin
        fmt_d = FMT_R;
        imm32 = '0;
      end
      default: begin
        fmt_d = FMT_ILL;
        imm32 = '0;
      end
    endcase

    // Legacy form holds half-word units; restore the byte offset here.
    if (BYTE_OFFSET != 0)
      offset = PC_W'($signed(imm32));
    else
      offset = PC_W'($signed({imm32, 1'b0}));

    new_e.inst    = inst_i;
    new_e.pc      = pc_i;
    new_e.imm     = XLEN'($signed(imm32));
    new_e.fmt     = fmt_d;
    new_e.illegal = (fmt_d == FMT_ILL);
    if (fmt_d == FMT_B || fmt_d == FMT_J)
      new_e.target = pc_i + offset;
    else
      new_e.target = pc_i + PC_W'(4);
  end

  // ---------------- two-entry FIFO ----------------
  entry_t head_q, skid_q;
  logic   head_v_q, skid_v_q, rdy_q;
  logic   push, pop;
  logic   head_v_n, skid_v_n;
  logic   head_ld_new, head_ld_skid, skid_ld_new;

  assign push = in_valid_i & rdy_q;
  assign pop  = head_v_q & out_ready_i;

  // Pop is resolved first so a same-cycle push sees the post-pop occupancy
  // and lands in whichever slot keeps FIFO order.
  always_comb begin
    head_v_n     = head_v_q;
    skid_v_n     = skid_v_q;
    head_ld_new  = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld_new  = 1'b0;
    if (flush_i) begin
      head_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else begin
      if (pop) begin
        if (skid_v_q) begin
          head_ld_skid = 1'b1;
          head_v_n     = 1'b1;
          skid_v_n     = 1'b0;
        end else begin
          head_v_n = 1'b0;
        end
      end
      if (push) begin
        if (!head_v_n) begin
          head_ld_new = 1'b1;
          head_v_n    = 1'b1;
        end else begin
          skid_ld_new = 1'b1;
          skid_v_n    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q   <= '0;
      skid_q   <= '0;
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      head_v_q <= head_v_n;
      skid_v_q <= skid_v_n;
      rdy_q    <= !skid_v_n;
      if (head_ld_new)
        head_q <= new_e;
      else if (head_ld_skid)
        head_q <= skid_q;
      if (skid_ld_new)
        skid_q <= new_e;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = head_v_q;
  assign inst_o      = head_q.inst;
  assign pc_o        = head_q.pc;
  assign imm_o       = head_q.imm;
  assign fmt_o       = head_q.fmt;
  assign target_o    = head_q.target;
  assign illegal_o   = head_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: scoreboard of expected entries pushed on
// accept and compared on each downstream pop, plus direct checks of the
// reference vectors, backpressure, flush, reset and parameter variants.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] inst, pc;
  logic        in_ready, out_valid, illegal;
  logic [31:0] inst_o, pc_o, imm_o, target_o;
  logic [2:0]  fmt_o;

  // secondary bus feeding the parameter-variant instances
  logic        s_valid;
  logic [31:0] s_inst, s_pc;
  logic        b0_ready, b0_valid, b0_ill;
  logic [31:0] b0_inst, b0_pc, b0_imm, b0_target;
  logic [2:0]  b0_fmt;
  logic        x_ready, x_valid, x_ill;
  logic [31:0] x_inst, x_pc, x_target;
  logic [63:0] x_imm;
  logic [2:0]  x_fmt;

  always #5 clk = ~clk;

  imm_gen_pipe dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_i(inst), .pc_i(pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .inst_o(inst_o), .pc_o(pc_o), .imm_o(imm_o), .fmt_o(fmt_o),
    .target_o(target_o), .illegal_o(illegal)
  );

  imm_gen_pipe #(.BYTE_OFFSET(0)) dut_b0 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
    .in_valid_i(s_valid), .in_ready_o(b0_ready),
    .inst_i(s_inst), .pc_i(s_pc),
    .out_valid_o(b0_valid), .out_ready_i(1'b1),
    .inst_o(b0_inst), .pc_o(b0_pc), .imm_o(b0_imm), .fmt_o(b0_fmt),
    .target_o(b0_target), .illegal_o(b0_ill)
  );

  imm_gen_pipe #(.XLEN(64)) dut_x64 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
    .in_valid_i(s_valid), .in_ready_o(x_ready),
    .inst_i(s_inst), .pc_i(s_pc),
    .out_valid_o(x_valid), .out_ready_i(1'b1),
    .inst_o(x_inst), .pc_o(x_pc), .imm_o(x_imm), .fmt_o(x_fmt),
    .target_o(x_target), .illegal_o(x_ill)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] target;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference decode (ISA byte-offset form), built with arithmetic shifts.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    logic signed [63:0] si;
    si = {{32{i[31]}}, i};
    e.inst = i;
    e.pc   = p;
    e.ill  = 1'b0;
    e.imm  = '0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: begin e.fmt = 3'd1; e.imm = si >>> 20; end
      7'h23: begin e.fmt = 3'd2; e.imm = ((si >>> 25) << 5) | 64'(i[11:7]); end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = ((si >>> 31) << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5)
              | (64'(i[11:8]) << 1);
      end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = (si >>> 12) << 12; end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = ((si >>> 31) << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11)
              | (64'(i[30:21]) << 1);
      end
      7'h33: e.fmt = 3'd0;
      default: begin e.fmt = 3'd7; e.ill = 1'b1; end
    endcase
    if (e.fmt == 3'd3 || e.fmt == 3'd5) e.target = p + e.imm[31:0];
    else e.target = p + 32'd4;
    return e;
  endfunction

  // One clock: score the handshakes visible now, then advance past the edge.
  task automatic tick();
    bit   pu, po;
    exp_t e;
    pu = in_valid && in_ready;
    po = out_valid && out_ready;
    if (flush) begin
      sb.delete();
    end else begin
      if (po) begin
        if (sb.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
        else begin
          e = sb.pop_front();
          check("inst", 64'(inst_o), 64'(e.inst));
          check("pc", 64'(pc_o), 64'(e.pc));
          check("imm", 64'(imm_o), 64'(e.imm[31:0]));
          check("fmt", 64'(fmt_o), 64'(e.fmt));
          check("target", 64'(target_o), 64'(e.target));
          check("illegal", 64'(illegal), 64'(e.ill));
        end
      end
      if (pu) sb.push_back(model(inst, pc));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p);
    bit acc;
    inst = i;
    pc = p;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      acc = in_ready;
      tick();
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 10 && sb.size() > 0; n++) begin
      check("drain_valid", 64'(out_valid), 64'd1);
      tick();
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("drain_no_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [6:0] ops [9];
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inst = '0; pc = '0; s_valid = 1'b0; s_inst = '0; s_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_imm", 64'(imm_o), 64'd0);
    check("rst_target", 64'(target_o), 64'd0);
    check("rst_pc_inst", 64'({pc_o, inst_o}), 64'd0);
    check("rst_fmt_ill", 64'({fmt_o, illegal}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // reference vectors, each visible one cycle after accept
    send(32'hFFF00093, 32'h0);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_imm", 64'(imm_o), 64'hFFFF_FFFF);
    check("addi_fmt", 64'(fmt_o), 64'd1);
    send(32'h00202423, 32'h4);
    check("sw_imm", 64'(imm_o), 64'd8);
    check("sw_fmt", 64'(fmt_o), 64'd2);
    send(32'h123450B7, 32'h8);
    check("lui_imm", 64'(imm_o), 64'h1234_5000);
    check("lui_fmt", 64'(fmt_o), 64'd4);
    send(32'hFE000EE3, 32'h100);
    check("beq_imm", 64'(imm_o), 64'hFFFF_FFFC);
    check("beq_target", 64'(target_o), 64'hFC);
    check("beq_fmt", 64'(fmt_o), 64'd3);
    send(32'h001000EF, 32'h40);
    check("jal_imm", 64'(imm_o), 64'h800);
    check("jal_target", 64'(target_o), 64'h840);
    check("jal_fmt", 64'(fmt_o), 64'd5);
    send(32'h0000007F, 32'h200);
    check("ill_fmt", 64'(fmt_o), 64'd7);
    check("ill_flag", 64'(illegal), 64'd1);
    check("ill_imm", 64'(imm_o), 64'd0);
    check("ill_target", 64'(target_o), 64'h204);
    drain();

    // backpressure: A,B accepted, C held until the head drains
    out_ready = 1'b0;
    send(32'h00A00513, 32'h1000);
    send(32'h00B00593, 32'h1004);
    check("bp_full_ready", 64'(in_ready), 64'd0);
    inst = 32'h00C00613; pc = 32'h1008; in_valid = 1'b1;
    repeat (3) tick();
    check("bp_hold_ready", 64'(in_ready), 64'd0);
    check("bp_hold_imm", 64'(imm_o), 64'd10);
    check("bp_sb_size", 64'(sb.size()), 64'd2);
    out_ready = 1'b1;
    for (int n = 0; n < 5 && in_valid; n++) begin
      if (in_ready) begin tick(); in_valid = 1'b0; end
      else tick();
    end
    check("bp_c_accepted", 64'(in_valid), 64'd0);
    drain();

    // random back-to-back stream with random backpressure
    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++)
      send({$urandom()} & 32'hFFFF_FF80 | 32'(ops[$urandom_range(0, 8)]), $urandom());
    rnd_ready = 1'b0;
    drain();

    // flush with both entries full and a concurrent push
    out_ready = 1'b0;
    send(32'h00100093, 32'h2000);
    send(32'h00200113, 32'h2004);
    inst = 32'h00300193; pc = 32'h2008; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (2) tick();
    check("flush_nothing", 64'(out_valid), 64'd0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(32'hFFF00093, 32'h3000);
    send(32'h123450B7, 32'h3004);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    check("arst_imm", 64'(imm_o), 64'd0);
    check("arst_pc_inst", 64'({pc_o, inst_o}), 64'd0);
    check("arst_target", 64'(target_o), 64'd0);
    sb.delete();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h00202423, 32'h44);
    check("post_rst_imm", 64'(imm_o), 64'd8);
    drain();

    // parameter variants
    s_inst = 32'hFE000EE3; s_pc = 32'h100; s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("b0_valid", 64'(b0_valid), 64'd1);
    check("b0_imm", 64'(b0_imm), 64'hFFFF_FFFE);
    check("b0_target", 64'(b0_target), 64'hFC);
    check("b0_fmt", 64'(b0_fmt), 64'd3);
    check("x64_beq_imm", x_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    s_inst = 32'h001000EF; s_pc = 32'h40; s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("b0_jal_imm", 64'(b0_imm), 64'h400);
    check("b0_jal_target", 64'(b0_target), 64'h840);
    s_inst = 32'hFFF00093; s_pc = 32'h0; s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("x64_valid", 64'(x_valid), 64'd1);
    check("x64_addi_imm", x_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("x64_addi_fmt", 64'(x_fmt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the ID stage of the pipelined RV32I core. It decodes every base format: R, I, S, B, U and J. It sign-extends the immediate to XLEN and computes the PC-relative target for branches and jumps. Results are presented through a valid/ready pipeline stage with a 2-entry skid buffer, so the stage supports stall (backpressure) and flush without dropping or duplicating instructions.

## Interface
Parameters:
- XLEN, 32: immediate output width (32 or 64).
- PC_W, 32: PC and target width.
- BYTE_OFFSET, 1: 1 gives B/J immediates as byte offsets with bit 0 = 0 (ISA form). 0 gives the legacy unshifted form: B is {inst[31],inst[7],inst[30:25],inst[11:8]} sign-extended, and J is the ISA value >>1.

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard all buffered and incoming entries.
- in_valid_i  in  1  upstream has an instruction.
- in_ready_o  out  1  stage can accept.
- inst_i  in  32  instruction word.
- pc_i  in  PC_W  instruction PC.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts the head.
- inst_o  out  32  head instruction.
- pc_o  out  PC_W  head PC.
- imm_o  out  XLEN  sign-extended immediate.
- fmt_o  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
- target_o  out  PC_W  branch/jump target.
- illegal_o  out  1  opcode not decoded.

## Operation
- Decode is by inst[6:0]:
  - I: 0000011, 0010011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011 (imm 0).
  - Anything else: fmt 7, illegal_o=1, imm 0, target pc+4.
- Immediate fields:
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - U: {inst[31:12],12'b0}.
  - B and J: per BYTE_OFFSET.
  - All are sign-extended from their top bit to XLEN.
- Target:
  - B/J: pc + byte offset (imm when BYTE_OFFSET=1, imm<<1 when 0), modulo 2^PC_W.
  - All other formats: pc+4.
  - imm is truncated to PC_W if XLEN > PC_W.
- Decode is combinational on the input side. All outputs come from the head register.
- Buffer is 2 entries (head + skid) in FIFO order.
- An entry is pushed when in_valid_i & in_ready_o; it is popped when out_valid_o & out_ready_i.
- Push and pop in the same cycle:
  - Skid full: skid moves to head, and the new entry goes to skid.
  - Otherwise: the new entry goes to head.
- in_ready_o = !skid_full. It is a registered state bit and does not depend combinationally on out_ready_i.
- out_valid_o = head_full.
- Flush: on the next edge both entries are invalidated, and any input pushed that cycle is discarded. A flush overrides push and pop.

## Timing
- Reset state:
  - out_valid_o=0 and in_ready_o=1.
  - imm_o, target_o, pc_o, inst_o and fmt_o are all 0; illegal_o=0.
  - Reset asserted mid-transfer drops all entries immediately (asynchronously).
- Latency: input accepted at edge N appears with out_valid_o=1 after edge N. Throughput is 1 instruction per cycle when out_ready_i is held high.
- While out_valid_o & !out_ready_i, all outputs hold stable.
- Upstream must hold inst_i/pc_i stable while in_valid_i & !in_ready_o.
- Empty: pop is impossible. Full (both entries): in_ready_o=0, and it returns to 1 the cycle after a pop or flush.
- Cycle after a flush: out_valid_o=0 and in_ready_o=1.

## Test plan
- Single-format decodes with defaults, PC_W=32:
  - 0xFFF00093 -> imm 0xFFFFFFFF, fmt 1, one cycle after accept.
  - 0x00202423 -> imm 8, fmt 2.
  - 0x123450B7 -> imm 0x12345000, fmt 4.
- Branch, beq -4: 0xFE000EE3 at pc 0x100.
  - BYTE_OFFSET=1 -> imm 0xFFFFFFFC, target 0xFC, fmt 3.
  - BYTE_OFFSET=0 -> imm 0xFFFFFFFE, target 0xFC.
- Jump: jal 0x001000EF at pc 0x40 -> imm 0x800, target 0x840, fmt 5.
- Edge decodes:
  - 0x0000007F -> fmt 7, illegal_o 1, imm 0, target pc+4.
  - XLEN=64 with 0xFFF00093 -> imm 0xFFFFFFFFFFFFFFFF.
- Backpressure: hold out_ready_i=0 and push A,B,C.
  - A and B are accepted; in_ready_o drops after B; C is held.
  - Release out_ready_i -> A,B,C drain on consecutive cycles, no loss or duplicates.
- Flush and reset:
  - Flush with both entries full plus a concurrent push -> next cycle out_valid_o=0, in_ready_o=1, nothing emitted.
  - rst_i pulsed mid-stream -> outputs return to 0 immediately.
